// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, operation encoding and field masks for m_csr_file.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [31:0] MSTATUS_MASK  = 32'h0000_0088;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  typedef enum logic [1:0] {
    CSR_OPS_NONE  = 2'b00,
    CSR_OPS_WRITE = 2'b01,
    CSR_OPS_SET   = 2'b10,
    CSR_OPS_CLEAR = 2'b11
  } csr_ops_e;
endpackage

// File: rtl/m_csr_file_if.sv
// m_csr_file_if: CSR access bus between EXE (master) and the CSR file (slave).
interface m_csr_file_if;
  logic        csr_rd_req;
  logic        csr_wr_req;
  logic [1:0]  csr_ops;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  modport master (output csr_rd_req, csr_wr_req, csr_ops, csr_addr, csr_wdata,
                  input csr_rdata, csr_illegal);
  modport slave  (input csr_rd_req, csr_wr_req, csr_ops, csr_addr, csr_wdata,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/m_csr_counter64.sv
// m_csr_counter64: 64-bit counter with independently writable 32-bit halves.
module m_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (wr_lo || wr_hi) begin
      // a half-write suppresses the carry between halves for this edge
      count[31:0] <= wr_lo ? wdata : count[31:0] + {31'b0, inc};
      if (wr_hi) count[63:32] <= wdata;
    end else count <= count + {63'b0, inc};
  end
endmodule

// File: rtl/m_csr_file.sv
// m_csr_file: machine-mode CSR file with counters, trap entry and mret handling.
module m_csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL = 32'h4000_1101,
  parameter logic [31:0] HART_ID  = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  m_csr_file_if.slave  bus,
  input  logic         instret_inc,
  input  logic         trap_valid,
  input  logic [31:0]  trap_cause,
  input  logic [31:0]  trap_pc,
  input  logic [31:0]  trap_tval,
  input  logic         mret,
  output logic [31:0]  mtvec_o,
  output logic [31:0]  mepc_o,
  output logic         mie_global_o
);
  logic        r_mie, r_mpie;
  logic [31:0] r_mie_reg, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0] w_cyc, w_ins;
  logic [31:0] w_old, w_new;
  logic        w_impl, w_do_wr;
  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:               w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      CSR_MISA:                  w_old = MISA_VAL;
      CSR_MIE:                   w_old = r_mie_reg;
      CSR_MTVEC:                 w_old = r_mtvec;
      CSR_MSCRATCH:              w_old = r_mscratch;
      CSR_MEPC:                  w_old = r_mepc;
      CSR_MCAUSE:                w_old = r_mcause;
      CSR_MTVAL:                 w_old = r_mtval;
      CSR_MIP:                   w_old = '0;
      CSR_MCYCLE, CSR_CYCLE:     w_old = w_cyc[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   w_old = w_cyc[63:32];
      CSR_MINSTRET, CSR_INSTRET: w_old = w_ins[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_old = w_ins[63:32];
      CSR_MHARTID:               w_old = HART_ID;
      default:                   w_impl = 1'b0;
    endcase
  end
  assign bus.csr_illegal = ((bus.csr_rd_req || bus.csr_wr_req) && !w_impl) ||
                           (bus.csr_wr_req && bus.csr_addr[11:10] == 2'b11);
  assign bus.csr_rdata = (bus.csr_rd_req && !bus.csr_illegal) ? w_old : '0;
  assign w_new = bus.csr_ops == CSR_OPS_WRITE ? bus.csr_wdata :
                 bus.csr_ops == CSR_OPS_SET   ? w_old | bus.csr_wdata :
                                                w_old & ~bus.csr_wdata;
  // a trapping instruction never commits its CSR write
  assign w_do_wr = bus.csr_wr_req && !bus.csr_illegal && bus.csr_ops != CSR_OPS_NONE && !trap_valid;
  m_csr_counter64 u_cycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .wr_lo(w_do_wr && bus.csr_addr == CSR_MCYCLE),
    .wr_hi(w_do_wr && bus.csr_addr == CSR_MCYCLEH),
    .wdata(w_new), .count(w_cyc)
  );
  m_csr_counter64 u_instret (
    .clk(clk), .rst(rst), .inc(instret_inc),
    .wr_lo(w_do_wr && bus.csr_addr == CSR_MINSTRET),
    .wr_hi(w_do_wr && bus.csr_addr == CSR_MINSTRETH),
    .wdata(w_new), .count(w_ins)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mie_reg  <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trap_valid) begin
      r_mepc   <= {trap_pc[31:2], 2'b00};
      r_mcause <= trap_cause;
      r_mtval  <= trap_tval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else begin
      if (mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
      if (w_do_wr)
        case (bus.csr_addr)
          CSR_MSTATUS: if (!mret) begin
            r_mie  <= w_new[MIE_BIT] & MSTATUS_MASK[MIE_BIT];
            r_mpie <= w_new[MPIE_BIT] & MSTATUS_MASK[MPIE_BIT];
          end
          CSR_MIE:      r_mie_reg  <= w_new & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_new;
          CSR_MTVAL:    r_mtval    <= w_new;
          default: ;
        endcase
    end
  end
  assign mtvec_o      = r_mtvec;
  assign mepc_o       = r_mepc;
  assign mie_global_o = r_mie;
endmodule

// File: tb/tb_m_csr_file.sv
// tb_m_csr_file: randomized and directed checks of m_csr_file against a behavioural model.
module tb_m_csr_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instret_inc = 1'b0, trap_valid = 1'b0, mret = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic [31:0] mtvec_o, mepc_o;
  logic mie_global_o;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  m_csr_file_if bus();
  m_csr_file dut (
    .clk(clk), .rst(rst), .bus(bus), .instret_inc(instret_inc),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mie_global_o(mie_global_o)
  );
  always #5 clk = ~clk;
  bit m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mrd(input logic [11:0] a, output logic [31:0] v, output bit impl);
    impl = 1;
    v = 0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: v = 32'h4000_1101;
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = 0;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF14: v = 0;
      default: impl = 0;
    endcase
  endtask
  function automatic bit m_ill(bit r, bit w, logic [11:0] a, bit impl);
    return ((r || w) && !impl) || (w && a >= 12'hC00);
  endfunction
  always @(posedge clk) begin
    logic [31:0] old, nv;
    logic [63:0] c, i;
    bit impl, ok;
    if (rst) begin
      {m_mie, m_mpie} = 0;
      {m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval} = 0;
      m_cyc = 0;
      m_ins = 0;
    end else begin
      mrd(bus.csr_addr, old, impl);
      ok = bus.csr_wr_req && !m_ill(bus.csr_rd_req, bus.csr_wr_req, bus.csr_addr, impl)
           && bus.csr_ops != 2'd0 && !trap_valid;
      nv = bus.csr_ops == 2'd1 ? bus.csr_wdata : bus.csr_ops == 2'd2 ? (old | bus.csr_wdata) : (old & ~bus.csr_wdata);
      c = m_cyc + 1;
      i = m_ins + 64'(instret_inc);
      if (ok) begin
        if (bus.csr_addr == 12'hB00) c = {m_cyc[63:32], nv};
        if (bus.csr_addr == 12'hB80) c = {nv, m_cyc[31:0] + 32'd1};
        if (bus.csr_addr == 12'hB02) i = {m_ins[63:32], nv};
        if (bus.csr_addr == 12'hB82) i = {nv, m_ins[31:0] + 32'(instret_inc)};
      end
      m_cyc = c;
      m_ins = i;
      if (trap_valid) begin
        m_mepc = trap_pc & ~32'd3;
        m_mcause = trap_cause;
        m_mtval = trap_tval;
        m_mpie = m_mie;
        m_mie = 0;
      end else begin
        if (ok)
          case (bus.csr_addr)
            12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_mie_reg = nv & 32'h888;
            12'h305: m_mtvec = nv & ~32'd3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            default: ;
          endcase
        if (mret) begin
          m_mie = m_mpie;
          m_mpie = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] v;
    bit impl, ill;
    if (chk_en) begin
      mrd(bus.csr_addr, v, impl);
      ill = m_ill(bus.csr_rd_req, bus.csr_wr_req, bus.csr_addr, impl);
      chk("rdata", bus.csr_rdata, (bus.csr_rd_req && !ill) ? v : 32'd0);
      chk("illegal", 32'(bus.csr_illegal), 32'(ill));
      chk("mtvec_o", mtvec_o, m_mtvec);
      chk("mepc_o", mepc_o, m_mepc);
      chk("mie_global_o", 32'(mie_global_o), 32'(m_mie));
    end
  end
  task automatic drv(bit r, bit w, logic [1:0] o, logic [11:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    bus.csr_rd_req = r;
    bus.csr_wr_req = w;
    bus.csr_ops = o;
    bus.csr_addr = a;
    bus.csr_wdata = d;
    rst = 0;
    trap_valid = 0;
    mret = 0;
    instret_inc = 0;
  endtask
  task automatic lit(string n, logic [31:0] e);
    #1 chk(n, bus.csr_rdata, e);
  endtask
  logic [11:0] pool [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
    12'hF14, 12'h7C0, 12'h000, 12'h345, 12'hF11};
  initial begin
    bus.csr_rd_req = 0; bus.csr_wr_req = 0; bus.csr_ops = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    @(posedge clk);
    @(posedge clk);
    #1 chk_en = 1;
    #1 chk("reset_mtvec", mtvec_o, 32'd0);
    chk("reset_mie_global", 32'(mie_global_o), 32'd0);
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 12'hB00, 0); lit("cycle_first", 32'd1);
    drv(1, 0, 0, 12'hB00, 0); lit("cycle_second", 32'd2);
    drv(1, 0, 0, 12'h301, 0); lit("misa", 32'h4000_1101);
    drv(1, 1, 1, 12'h340, 32'hDEAD_BEEF); lit("scratch_w_old", 32'd0);
    drv(1, 1, 2, 12'h340, 32'h0000_0010); lit("scratch_s_old", 32'hDEAD_BEEF);
    drv(1, 1, 3, 12'h340, 32'hFF00_0000); lit("scratch_c_old", 32'hDEAD_BEFF);
    drv(1, 0, 0, 12'h340, 0); lit("scratch_final", 32'h00AD_BEFF);
    drv(0, 1, 1, 12'hC00, 32'h1234); #1 chk("wr_cycle_illegal", 32'(bus.csr_illegal), 32'd1);
    drv(1, 0, 0, 12'h7C0, 0); #1 chk("rd_7c0_illegal", 32'(bus.csr_illegal), 32'd1);
    chk("rd_7c0_data", bus.csr_rdata, 32'd0);
    drv(1, 1, 2, 12'h300, 32'h8); lit("mstatus_pre", 32'h1800);
    drv(1, 1, 1, 12'h340, 32'h1234_5678);
    trap_valid = 1; trap_cause = 2; trap_pc = 32'h8000_0102; trap_tval = 32'h77;
    drv(1, 0, 0, 12'h341, 0); lit("trap_mepc", 32'h8000_0100);
    drv(1, 0, 0, 12'h300, 0); lit("trap_mstatus", 32'h0000_1880);
    drv(1, 0, 0, 12'h340, 0); lit("trap_scratch_kept", 32'h00AD_BEFF);
    drv(0, 0, 0, 0, 0); mret = 1;
    drv(1, 0, 0, 12'h300, 0); lit("mret_mstatus", 32'h0000_1888);
    drv(1, 1, 1, 12'hB80, 32'h0);
    drv(1, 1, 1, 12'hB00, 32'hFFFF_FFFF);
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 12'hB80, 0); lit("mcycleh_carry", 32'd1);
    drv(1, 1, 1, 12'hB02, 32'hFFFF_FFFF);
    drv(1, 1, 1, 12'hB82, 32'h0000_0055); instret_inc = 1;
    drv(1, 0, 0, 12'hB82, 0); lit("minstreth_written", 32'h55);
    drv(1, 0, 0, 12'hB02, 0); lit("minstret_low_wrapped", 32'd0);
    for (int k = 0; k < 3000; k++) begin
      drv($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom),
          ($urandom % 16 == 0) ? 12'($urandom) : pool[$urandom_range(0, 21)],
          ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom);
      instret_inc = $urandom_range(0, 1);
      trap_valid = ($urandom % 24 == 0);
      mret = ($urandom % 16 == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
      rst = ($urandom % 600 == 0);
    end
    drv(1, 1, 1, 12'h340, 32'hCAFE_F00D);
    rst = 1; trap_valid = 1; trap_pc = 32'h4000_0006; trap_cause = 7;
    drv(1, 0, 0, 12'h340, 0); lit("rst_scratch", 32'd0);
    drv(1, 0, 0, 12'h300, 0); lit("rst_mstatus", 32'h1800);
    #1 chk("rst_mepc", mepc_o, 32'd0);
    drv(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m_csr_file.md
# m_csr_file

Machine-mode CSR register file for the RV32 core; the responder for the `csr_rd_req`/`csr_wr_req`/`csr_ops` requests produced in EXE. It returns the old CSR value in the same cycle and applies the CSRRW/CSRRS/CSRRC read-modify-write at the next edge. It flags illegal accesses and runs the 64-bit cycle and instret counters. It also performs the trap-entry and `mret` updates of `mstatus`, `mepc`, `mcause` and `mtval`.

## Interface
- Parameters:
  - `MISA_VAL`, default `32'h4000_1101`, RV32IMA value returned by `misa`.
  - `HART_ID`, default `0`, value returned by `mhartid`.
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `rst` in 1: reset, synchronous, active-high.
  - `csr_rd_req` in 1: read requested.
  - `csr_wr_req` in 1: write requested.
  - `csr_ops` in 2: 00 NONE, 01 WRITE, 10 SET, 11 CLEAR.
  - `csr_addr` in 12: instruction[31:20].
  - `csr_wdata` in 32: rs1 value or zero-extended uimm, selected upstream.
  - `instret_inc` in 1: one instruction retired this cycle.
  - `trap_valid` in 1: take a trap this cycle.
  - `trap_cause` in 32, `trap_pc` in 32, `trap_tval` in 32: trap information.
  - `mret` in 1: `mret` retiring this cycle.
  - `csr_rdata` out 32: old value at `csr_addr`; combinational.
  - `csr_illegal` out 1: access is illegal; combinational.
  - `mtvec_o` out 32, `mepc_o` out 32: registered values.
  - `mie_global_o` out 1: `mstatus.MIE`.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300: MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - `misa` 0x301: read-only, `MISA_VAL`; writes are ignored without trapping.
  - `mie` 0x304: bits 3, 7, 11 are writable.
  - `mtvec` 0x305: bits [1:0] are forced to 0 (direct mode).
  - `mscratch` 0x340: full 32-bit read/write.
  - `mepc` 0x341: bits [1:0] are forced to 0.
  - `mcause` 0x342 and `mtval` 0x343: full 32-bit read/write.
  - `mip` 0x344: reads 0.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: read/write.
  - `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows of the machine counters.
  - `mhartid` 0xF14: read-only, `HART_ID`.
- Write value computation:
  - Write value: WRITE → `csr_wdata`; SET → `old | csr_wdata`; CLEAR → `old & ~csr_wdata`.
  - The result is then passed through each CSR's writable mask.
  - `csr_ops`=NONE with `csr_wr_req` writes nothing.
- `csr_illegal` = (`csr_rd_req` | `csr_wr_req`) & address not implemented, OR `csr_wr_req` & `csr_addr[11:10]`==2'b11.
  - An illegal access performs no update.
  - An illegal access drives `csr_rdata`=0.
- `csr_rdata` is valid whenever `csr_rd_req`=1; with `csr_rd_req`=0 it is 0.
- Counters:
  - `mcycle` increments every cycle.
  - `minstret` increments when `instret_inc`=1.
  - Both are 64-bit and wrap from all-ones to 0.
- Trap entry (`trap_valid`):
  - `mepc` ← `trap_pc & ~3`; `mcause` ← `trap_cause`; `mtval` ← `trap_tval`.
  - MPIE ← MIE; MIE ← 0.
- `mret`: MIE ← MPIE; MPIE ← 1.

## Timing
- Reset:
  - All writable CSRs and both counters are 0; MIE=MPIE=0.
  - `mtvec_o`=`mepc_o`=0; `mie_global_o`=0.
  - Combinational outputs follow from these values.
- Latency:
  - Reads are 0-cycle: they return the pre-edge value.
  - Writes are visible at `csr_rdata` the cycle after the edge.
- Priority within one cycle: `trap_valid` > `mret` > CSR write.
  - With `trap_valid`=1, any CSR write that cycle is dropped entirely (the instruction is trapping).
  - `mret` and a CSR write in the same cycle: the `mret` update wins for `mstatus`; writes to other CSRs proceed.
- Counter vs. software write at the same edge:
  - A write to the low half loads the low half; the high half holds, with no carry that cycle.
  - A write to the high half loads the high half; the low half increments normally, and its carry is discarded that cycle.
- Wrap: `mcycle`=`64'hFFFF_FFFF_FFFF_FFFF` → 0 at the next edge.
- `rst` asserted mid-stream overrides trap, `mret`, writes and increments at that edge.

## Structure
- `csr_pkg` holds:
  - CSR address localparams.
  - `csr_ops` enum: CSR_OPS_NONE/WRITE/SET/CLEAR.
  - Writable masks for `mstatus`/`mie`.
  - MIE/MPIE bit indices.
- Sub-module `m_csr_counter64`, instantiated for cycle and instret:
  - Ports: `clk`, `rst`, `inc`, `wr_lo`, `wr_hi`, `wdata[31:0]`, `count[63:0]`.
  - Implements the half-write/carry rules above.

## Test plan
- Reset, then read 0xB00 on two consecutive cycles → 1, then 2. Read 0x301 → `32'h4000_1101`.
- WRITE 0x340 with `32'hDEAD_BEEF`, then SET with `32'h0000_0010`, then CLEAR with `32'hFF00_0000`. Each cycle's `csr_rdata` shows the prior value; the final read is `32'h00AD_BEFF`.
- `csr_wr_req` to 0xC00 → `csr_illegal`=1 and `cycle` is unaffected. Read of 0x7C0 → `csr_illegal`=1 and `csr_rdata`=0.
- SET `mstatus` 0x8, then `trap_valid` with cause 2, pc `32'h8000_0102`, plus a simultaneous WRITE to `mscratch`:
  - Expected: `mepc`=`32'h8000_0100`, `mstatus`=`32'h0000_1880`, `mscratch` unchanged.
  - Then `mret` → `mstatus`=`32'h0000_1888`.
- WRITE `mcycle`=`32'hFFFF_FFFF` with `mcycleh`=0 → the next read of `mcycleh` is 1.
  - WRITE `minstreth` while `instret_inc`=1 and low=`32'hFFFF_FFFF` → high = written value; low = 0.
- Assert `rst` in the same cycle as `trap_valid` and a CSR write → all CSRs read their reset values the next cycle.
